// File: rtl/probe_capture.sv
// Logic-analyser capture engine: circular pre/post-trigger buffer, streamed out oldest-first.
// Define PROBE_EDGE_TRIG_EN for rising-edge trigger; default is a level trigger.
module probe_capture #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [ADDR_W-1:0] pre_len_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              rd_last_o,
  output logic              triggered_o,
  output logic [2:0]        state_o
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    READ = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic              match;
  logic              fire;
  logic [CW-1:0]     post_len;

  assign match    = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
  assign post_len = CW'(DEPTH) - {1'b0, pre_q};

`ifdef PROBE_EDGE_TRIG_EN
  logic prev_q, prev_d;

  assign fire = match & ~prev_q;

  always_comb begin
    prev_d = prev_q;
    if (state_q == IDLE && arm_i)
      prev_d = 1'b0;
    else if (state_q == FILL || state_q == WAIT)
      prev_d = match;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) prev_q <= 1'b0;
    else         prev_q <= prev_d;
  end
`else
  assign fire = match;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    trig_d  = trig_q;
    vld_d   = vld_q;
    last_d  = last_q;
    data_d  = data_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = FILL;
          pre_d   = pre_len_i;
          trig_d  = 1'b0;
          wptr_d  = '0;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (pre_q == '0) begin
          state_d = WAIT;
        end else begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == {1'b0, pre_q})
            state_d = WAIT;
        end
      end
      WAIT: begin
        we     = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (fire) begin
          trig_d = 1'b1;
          rptr_d = wptr_q - pre_q;
          if (post_len == CW'(1)) begin
            state_d = READ;
            cnt_d   = '0;
          end else begin
            state_d = POST;
            cnt_d   = CW'(1);
          end
        end
      end
      POST: begin
        we     = 1'b1;
        wptr_d = wptr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q + 1'b1 == post_len) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        // Output register doubles as the synchronous RAM read stage.
        if (vld_q && rd_ready_i && last_q) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
        end else if ((!vld_q || rd_ready_i) && cnt_q != CW'(DEPTH)) begin
          data_d = mem_q[rptr_q];
          vld_d  = 1'b1;
          last_d = (cnt_q == CW'(DEPTH - 1));
          rptr_d = rptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else if (vld_q && rd_ready_i) begin
          vld_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      trig_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (we) mem_q[wptr_q] <= probe_i;
  end

  assign rd_data_o   = data_q;
  assign rd_valid_o  = vld_q;
  assign rd_last_o   = last_q;
  assign triggered_o = trig_q;
  assign state_o     = state_q;

endmodule
